// File: rtl/playseq_motor_n_if.sv
// Board-side bundle of the sequence-game engine: start/mode/length/buttons in,
// LEDs, status flags, position and win/loss metrics out.
interface playseq_motor_n_if #(
  parameter int N_BOTOES = 4,
  parameter int AW       = 4
);
  logic                iniciar;
  logic [1:0]          modo;
  logic [AW:0]         comprimento;
  logic [N_BOTOES-1:0] botoes;
  logic                zera_metricas;
  logic [N_BOTOES-1:0] leds;
  logic                ocupado;
  logic                ganhou;
  logic                perdeu;
  logic                timeout;
  logic                gravado;
  logic [AW:0]         rodada;
  logic [AW-1:0]       indice;
  logic [3:0]          ganhos;
  logic [3:0]          perdas;
  logic [3:0]          db_estado;

  modport master (
    output iniciar, modo, comprimento, botoes, zera_metricas,
    input  leds, ocupado, ganhou, perdeu, timeout, gravado, rodada, indice,
           ganhos, perdas, db_estado
  );

  modport slave (
    input  iniciar, modo, comprimento, botoes, zera_metricas,
    output leds, ocupado, ganhou, perdeu, timeout, gravado, rodada, indice,
           ganhos, perdas, db_estado
  );
endinterface

// File: rtl/playseq_motor_n.sv
// Sequence-game engine: generates (LFSR) or records a symbol sequence, previews it
// on LEDs, checks player presses with a per-move timeout and keeps win/loss counts.
module playseq_motor_n #(
  parameter int          N_BOTOES = 4,
  parameter int          PROF     = 16,
  parameter int          T_LED    = 500,
  parameter int          T_GAP    = 100,
  parameter int          T_JOGADA = 5000,
  parameter logic [15:0] SEMENTE  = 16'hACE1
) (
  input logic               clock,
  input logic               reset_n,
  playseq_motor_n_if.slave  bus
);
  localparam int SW = $clog2(N_BOTOES);
  localparam int AW = $clog2(PROF);
  localparam int LW = (T_LED > 1) ? $clog2(T_LED) : 1;
  localparam int GW = (T_GAP > 1) ? $clog2(T_GAP) : 1;
  localparam int JW = (T_JOGADA > 1) ? $clog2(T_JOGADA) : 1;

  typedef enum logic [3:0] {
    IDLE = 4'd0, GERA = 4'd1, PREV_ON = 4'd2, PREV_OFF = 4'd3, ESPERA = 4'd4,
    SOLTA = 4'd5, GRAVA = 4'd6, GANHOU = 4'd7, PERDEU = 4'd8
  } estado_t;

  estado_t             estado, prox;
  logic [15:0]         lfsr;
  logic [SW-1:0]       seq [PROF];
  logic [AW:0]         len_r, rodada_r, len_clamp;
  logic [AW-1:0]       indice_r;
  logic [3:0]          ganhos_r, perdas_r;
  logic                tmo_r, gravado_r, prev_any, pend_vld;
  logic [SW-1:0]       pend_sym, btn_sym;
  logic [LW-1:0]       tmr_led;
  logic [GW-1:0]       tmr_gap;
  logic [JW-1:0]       tmr_jog;
  logic [N_BOTOES-1:0] exp_oh, leds;
  logic                any_btn, press, btn_onehot, last_idx, last_len, start;
  logic                led_done, gap_done, jog_done;

  assign any_btn    = |bus.botoes;
  assign press      = any_btn && !prev_any;
  assign btn_onehot = any_btn && ((bus.botoes & (bus.botoes - 1'b1)) == '0);
  assign exp_oh     = N_BOTOES'(1) << seq[indice_r];
  assign last_idx   = ({1'b0, indice_r} == rodada_r - 1'b1);
  assign last_len   = ({1'b0, indice_r} == len_r - 1'b1);
  assign start      = bus.iniciar && (estado == IDLE || estado == GANHOU || estado == PERDEU);
  assign led_done   = (tmr_led == LW'(T_LED - 1));
  assign gap_done   = (tmr_gap == GW'(T_GAP - 1));
  assign jog_done   = (tmr_jog == JW'(T_JOGADA - 1));

  always_comb begin
    len_clamp = bus.comprimento;
    if (bus.comprimento == '0) len_clamp = (AW+1)'(1);
    else if (bus.comprimento > (AW+1)'(PROF)) len_clamp = (AW+1)'(PROF);
  end

  always_comb begin
    btn_sym = '0;
    for (int i = 0; i < N_BOTOES; i++)
      if (bus.botoes[i]) btn_sym = SW'(i);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= IDLE;
    else          estado <= prox;
  end

  always_comb begin
    prox = estado;
    leds = '0;
    case (estado)
      IDLE, GANHOU, PERDEU: begin
        if (estado == GANHOU) leds = '1;
        if (estado == PERDEU) leds = exp_oh;
        if (start) begin
          case (bus.modo)
            2'd0, 2'd1: prox = GERA;
            2'd2:       prox = PREV_ON;
            default:    prox = GRAVA;
          endcase
        end
      end
      GERA:     if (last_len) prox = PREV_ON;
      PREV_ON: begin
        leds = exp_oh;
        if (led_done) prox = PREV_OFF;
      end
      PREV_OFF: if (gap_done) prox = last_idx ? ESPERA : PREV_ON;
      ESPERA: begin
        leds = bus.botoes;
        // a press evaluated on the expiry cycle wins over the timeout
        if (press)         prox = (bus.botoes == exp_oh) ? SOLTA : PERDEU;
        else if (jog_done) prox = PERDEU;
      end
      SOLTA: begin
        leds = bus.botoes;
        if (!any_btn) begin
          if (!last_idx)              prox = ESPERA;
          else if (rodada_r < len_r)  prox = PREV_ON;
          else                        prox = GANHOU;
        end
      end
      GRAVA:    if (!any_btn && pend_vld && last_len) prox = IDLE;
      default:  prox = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr      <= SEMENTE;
      for (int i = 0; i < PROF; i++) seq[i] <= '0;
      len_r     <= '0;
      rodada_r  <= '0;
      indice_r  <= '0;
      ganhos_r  <= '0;
      perdas_r  <= '0;
      tmo_r     <= 1'b0;
      gravado_r <= 1'b0;
      prev_any  <= 1'b0;
      pend_vld  <= 1'b0;
      pend_sym  <= '0;
      tmr_led   <= '0;
      tmr_gap   <= '0;
      tmr_jog   <= '0;
    end else begin
      lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      prev_any <= any_btn;
      tmr_led  <= (estado == PREV_ON && prox == PREV_ON) ? tmr_led + 1'b1 : '0;
      tmr_gap  <= (estado == PREV_OFF && prox == PREV_OFF) ? tmr_gap + 1'b1 : '0;
      // the move timer holds its value outside ESPERA and restarts on every entry
      if (prox == ESPERA && estado != ESPERA)      tmr_jog <= '0;
      else if (estado == ESPERA && prox == ESPERA) tmr_jog <= tmr_jog + 1'b1;

      if (start) begin
        len_r    <= len_clamp;
        rodada_r <= (bus.modo == 2'd1) ? len_clamp : (AW+1)'(1);
        indice_r <= '0;
        tmo_r    <= 1'b0;
        pend_vld <= 1'b0;
      end else begin
        case (estado)
          GERA: begin
            seq[indice_r] <= lfsr[SW-1:0];
            indice_r      <= last_len ? '0 : indice_r + 1'b1;
          end
          PREV_OFF: if (gap_done) indice_r <= last_idx ? '0 : indice_r + 1'b1;
          ESPERA:   if (!press && jog_done) tmo_r <= 1'b1;
          SOLTA: begin
            if (!any_btn) begin
              if (!last_idx) indice_r <= indice_r + 1'b1;
              else if (rodada_r < len_r) begin
                rodada_r <= rodada_r + 1'b1;
                indice_r <= '0;
              end
            end
          end
          GRAVA: begin
            if (press) begin
              pend_vld <= btn_onehot;
              pend_sym <= btn_sym;
            end else if (!any_btn && pend_vld) begin
              seq[indice_r] <= pend_sym;
              pend_vld      <= 1'b0;
              if (last_len) gravado_r <= 1'b1;
              else          indice_r  <= indice_r + 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (bus.zera_metricas) begin
        ganhos_r <= '0;
        perdas_r <= '0;
      end else begin
        if (prox == GANHOU && estado != GANHOU && ganhos_r != 4'hF) ganhos_r <= ganhos_r + 1'b1;
        if (prox == PERDEU && estado != PERDEU && perdas_r != 4'hF) perdas_r <= perdas_r + 1'b1;
      end
    end
  end

  assign bus.leds      = leds;
  assign bus.ocupado   = !(estado == IDLE || estado == GANHOU || estado == PERDEU);
  assign bus.ganhou    = (estado == GANHOU);
  assign bus.perdeu    = (estado == PERDEU);
  assign bus.timeout   = (estado == PERDEU) && tmo_r;
  assign bus.gravado   = gravado_r;
  assign bus.rodada    = rodada_r;
  assign bus.indice    = indice_r;
  assign bus.ganhos    = ganhos_r;
  assign bus.perdas    = perdas_r;
  assign bus.db_estado = estado;
endmodule

// File: tb/tb_playseq_motor_n.sv
// Directed bench for playseq_motor_n: record, progressive, fixed-random, timeout,
// wrong/multi-hot presses, async reset and metric saturation/clear.
module tb_playseq_motor_n;
  localparam int NB = 4, PROF = 8, AW = 3, T_LED = 4, T_GAP = 2, T_JOG = 20;
  localparam logic [3:0] S_IDLE = 4'd0, S_GERA = 4'd1, S_PON = 4'd2, S_ESP = 4'd4,
                         S_SOLTA = 4'd5, S_GRAVA = 4'd6;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] m_lfsr;
  logic [1:0]  exp_seq [8];

  playseq_motor_n_if #(.N_BOTOES(NB), .AW(AW)) bus ();

  playseq_motor_n #(
    .N_BOTOES(NB), .PROF(PROF), .T_LED(T_LED), .T_GAP(T_GAP),
    .T_JOGADA(T_JOG), .SEMENTE(16'hACE1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // reference LFSR: Galois x^16+x^14+x^13+x^11+1, right-shifting
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [1:0] m, input int len);
    bus.iniciar     = 1'b1;
    bus.modo        = m;
    bus.comprimento = 4'(len);
    tick();
    bus.iniciar = 1'b0;
  endtask

  task automatic press(input logic [3:0] b, input logic z);
    bus.botoes = b;
    tick();
    bus.botoes        = '0;
    bus.zera_metricas = z;
    tick();
    bus.zera_metricas = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s);
    int n = 0;
    while (bus.db_estado !== s && n < 100) begin
      tick();
      n++;
    end
    if (bus.db_estado !== s) chk("wait_state", bus.db_estado, s);
  endtask

  task automatic check_preview(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      int cnt = 0;
      logic [3:0] v;
      while (bus.leds == 4'b0 && w < 50) begin
        tick();
        w++;
      end
      v = bus.leds;
      while (bus.leds == v && cnt < 20) begin
        tick();
        cnt++;
      end
      chk("prev_led", v, 32'(4'b0001 << exp_seq[i]));
      chk("prev_len", cnt, T_LED);
    end
  endtask

  task automatic play_prog(input int len);
    for (int r = 1; r <= len; r++) begin
      chk("rodada", bus.rodada, r);
      check_preview(r);
      wait_state(S_ESP);
      for (int i = 0; i < r; i++) press(4'b0001 << exp_seq[i], 1'b0);
    end
    chk("win_flag", bus.ganhou, 1);
    chk("win_leds", bus.leds, 4'hF);
  endtask

  initial begin
    int k;
    int n;
    logic [1:0] ws;
    bus.iniciar = 1'b0;
    bus.modo = 2'd0;
    bus.comprimento = '0;
    bus.botoes = '0;
    bus.zera_metricas = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_leds", bus.leds, 0);
    chk("rst_state", bus.db_estado, S_IDLE);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_ganhos", bus.ganhos, 0);
    chk("rst_perdas", bus.perdas, 0);
    chk("rst_gravado", bus.gravado, 0);
    chk("rst_rodada", bus.rodada, 0);
    chk("rst_indice", bus.indice, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // record 0,1,2 then play it progressively
    start(2'd3, 3);
    chk("grava_state", bus.db_estado, S_GRAVA);
    press(4'b0001, 1'b0);
    press(4'b0010, 1'b0);
    press(4'b0100, 1'b0);
    chk("rec1_gravado", bus.gravado, 1);
    chk("rec1_idle", bus.db_estado, S_IDLE);
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
    start(2'd2, 3);
    play_prog(3);
    chk("ganhos_1", bus.ganhos, 1);

    // fixed-random: capture GERA writes from the reference LFSR
    start(2'd1, 4);
    chk("gera_state", bus.db_estado, S_GERA);
    k = 0;
    while (bus.db_estado == S_GERA && k < 8) begin
      exp_seq[k] = m_lfsr[1:0];
      k++;
      tick();
    end
    chk("gera_len", k, 4);
    chk("fixed_rodada", bus.rodada, 4);
    check_preview(4);
    wait_state(S_ESP);
    press(4'b0001 << exp_seq[0], 1'b0);
    ws = exp_seq[1] + 2'd1;
    press(4'b0001 << ws, 1'b0);
    chk("wrong_perdeu", bus.perdeu, 1);
    chk("wrong_leds", bus.leds, 32'(4'b0001 << exp_seq[1]));
    chk("wrong_perdas", bus.perdas, 1);
    chk("wrong_timeout", bus.timeout, 0);

    // timeout after T_JOGADA cycles of ESPERA
    start(2'd2, 3);
    check_preview(1);
    wait_state(S_ESP);
    n = 0;
    while (bus.db_estado == S_ESP && n < 30) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, T_JOG);
    chk("tmo_perdeu", bus.perdeu, 1);
    chk("tmo_flag", bus.timeout, 1);
    chk("tmo_perdas", bus.perdas, 2);
    chk("tmo_leds", bus.leds, 32'(4'b0001 << exp_seq[0]));

    // press on the expiry cycle wins; then a multi-hot press loses
    start(2'd2, 3);
    check_preview(1);
    wait_state(S_ESP);
    repeat (T_JOG - 1) tick();
    chk("edge_still_esp", bus.db_estado, S_ESP);
    bus.botoes = 4'b0001 << exp_seq[0];
    tick();
    chk("edge_solta", bus.db_estado, S_SOLTA);
    bus.botoes = '0;
    tick();
    check_preview(2);
    wait_state(S_ESP);
    press(4'b0110, 1'b0);
    chk("multi_perdeu", bus.perdeu, 1);
    chk("multi_timeout", bus.timeout, 0);
    chk("multi_perdas", bus.perdas, 3);

    // record with an ignored multi-hot press, then replay 2,0,3
    start(2'd3, 3);
    press(4'b0100, 1'b0);
    chk("rec2_idx1", bus.indice, 1);
    press(4'b0011, 1'b0);
    chk("rec2_ignored", bus.indice, 1);
    press(4'b0001, 1'b0);
    press(4'b1000, 1'b0);
    chk("rec2_gravado", bus.gravado, 1);
    chk("rec2_idle", bus.db_estado, S_IDLE);
    exp_seq[0] = 2'd2; exp_seq[1] = 2'd0; exp_seq[2] = 2'd3;
    start(2'd2, 3);
    play_prog(3);
    chk("ganhos_2", bus.ganhos, 2);

    // asynchronous reset in the middle of a preview
    start(2'd2, 3);
    tick();
    chk("mid_pon", bus.db_estado, S_PON);
    reset_n = 1'b0;
    #1;
    chk("arst_state", bus.db_estado, S_IDLE);
    chk("arst_leds", bus.leds, 0);
    chk("arst_ganhos", bus.ganhos, 0);
    chk("arst_perdas", bus.perdas, 0);
    chk("arst_rodada", bus.rodada, 0);
    chk("arst_gravado", bus.gravado, 0);
    #2;
    reset_n = 1'b1;
    tick();

    // store is cleared to symbol 0: sixteen L=1 wins saturate at 15
    for (int g = 0; g < 16; g++) begin
      start(2'd2, 1);
      wait_state(S_ESP);
      press(4'b0001, 1'b0);
      chk("sat_ganhos", bus.ganhos, (g + 1 > 15) ? 15 : g + 1);
    end
    start(2'd2, 1);
    wait_state(S_ESP);
    press(4'b0001, 1'b1);
    chk("zera_ganhou", bus.ganhou, 1);
    chk("zera_ganhos", bus.ganhos, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/playseq_motor_n.md
Name: playseq_motor_n

Overview:
- Parametrised successor of the PlaySeq datapath: a self-contained sequence-game engine with its own control FSM.
- It generates or records a sequence of button symbols, then plays it back on LEDs (preview).
- It checks the player's presses with a per-move timeout and keeps win/loss metrics.
- Generalised in button count, sequence depth and timing, and adds LFSR-random, progressive and record modes the fixed-ROM datapath lacks.
- Sits between the debounced button/LED board interface and the top-level game wrapper.

Parameters:
N_BOTOES, 4, number of buttons/LEDs; must be 2, 4 or 8; SW = log2(N_BOTOES).
PROF, 16, maximum sequence depth; AW = $clog2(PROF).
T_LED, 500, clock cycles each preview LED stays lit.
T_GAP, 100, clock cycles of dark gap after each preview LED.
T_JOGADA, 5000, clock cycles allowed per player move before timeout.
SEMENTE, 16'hACE1, non-zero reset value of the 16-bit LFSR.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset_n  in  1  asynchronous, active-low reset.
iniciar  in  1  start pulse; accepted only in IDLE, GANHOU or PERDEU.
modo  in  2  latched at start: 0 progressive-random, 1 fixed-random, 2 progressive-memory, 3 record.
comprimento  in  AW+1  target length L, latched at start; 0 is treated as 1, values above PROF as PROF.
botoes  in  N_BOTOES  synchronised, debounced buttons; active high.
zera_metricas  in  1  synchronous clear of ganhos/perdas.
leds  out  N_BOTOES  LED drive.
ocupado  out  1  high in every state except IDLE, GANHOU, PERDEU.
ganhou  out  1  high while in GANHOU.
perdeu  out  1  high while in PERDEU.
timeout  out  1  high while in PERDEU if the loss was caused by timeout.
gravado  out  1  set when record completes; cleared by reset_n only.
rodada  out  AW+1  current round length.
indice  out  AW  current sequence position.
ganhos  out  4  wins, saturating at 15.
perdas  out  4  losses, saturating at 15.
db_estado  out  4  FSM state encoding.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; leds, rodada, indice, ganhos, perdas, flags all 0.
  - Sequence store (PROF x SW registers) cleared to 0; LFSR = SEMENTE.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every clock in every state.
  - A symbol is the low SW bits; the expected one-hot value is 1<<symbol.
- States: IDLE, GERA, PREV_ON, PREV_OFF, ESPERA, SOLTA, GRAVA, GANHOU, PERDEU.
- Start: iniciar in IDLE/GANHOU/PERDEU latches modo and L (clamped), clears ganhou/perdeu/timeout and sets indice=0.
  - modo 0/1 -> GERA.
  - modo 2 -> PREV_ON.
  - modo 3 -> GRAVA.
  - iniciar in any other state is ignored.
- GERA: writes the current LFSR symbol to seq[indice] once per cycle for L cycles, then PREV_ON with indice=0.
- Round length: rodada = 1 in progressive modes (0, 2); rodada = L in fixed mode (1).
- PREV_ON: leds = onehot(seq[indice]) for exactly T_LED cycles, then PREV_OFF.
- PREV_OFF: leds = 0 for T_GAP cycles.
  - If indice = rodada-1 -> ESPERA with indice=0.
  - Otherwise indice+1 -> PREV_ON.
- ESPERA:
  - leds mirror botoes.
  - The timeout counter clears on entry and counts every cycle.
  - A press is the first cycle with |botoes=1 after a cycle with |botoes=0; it is evaluated that same cycle.
  - botoes == onehot(seq[indice]) -> SOLTA; any other value, including multi-hot -> PERDEU.
  - If the counter reaches T_JOGADA-1 with no press -> PERDEU with timeout=1.
  - A press in the same cycle as expiry takes priority over the timeout.
- SOLTA:
  - leds mirror botoes; the timer is frozen; wait for botoes == 0.
  - If indice < rodada-1: indice+1 -> ESPERA.
  - Else if rodada < L: rodada+1, indice=0 -> PREV_ON.
  - Else -> GANHOU.
- GRAVA:
  - On each press that is exactly one-hot, store its symbol at seq[indice] on release; multi-hot presses are ignored.
  - After the L-th store: gravado=1 -> IDLE. No timeout in GRAVA.
- GANHOU: leds all ones; ganhos+1 on entry (saturating).
- PERDEU: leds = onehot(seq[indice]) to show the correct answer; perdas+1 on entry (saturating).
- zera_metricas: zera_metricas clears ganhos/perdas. If it coincides with a metric increment, the clear wins.
- Timer widths: each timer is sized by $clog2 of its own parameter; no wrap beyond its terminal count.

Test Plan:
(Sim parameters: N_BOTOES=4, PROF=8, T_LED=4, T_GAP=2, T_JOGADA=20.)
- Reset then modo=2, L=3, seq preloaded 0,1,2, all presses correct -> previews of lengths 1, 2, 3, with each LED high exactly 4 cycles; GANHOU, leds=4'b1111, ganhos=1.
- modo=1, L=4: the bench's LFSR model predicts the GERA writes -> a single preview of 4 symbols matching the model; a wrong second press -> PERDEU, leds show the expected symbol, perdas=1, timeout=0.
- In ESPERA, hold botoes=0 for 20 cycles -> PERDEU on cycle 19 after entry, timeout=1; a press on exactly that cycle -> SOLTA instead.
- modo=3, L=3, press 4'b0100, 4'b0011 (ignored), 4'b0001, 4'b1000 -> gravado=1; then modo=2 previews 2, 0, 3.
- Press 4'b0110 in ESPERA -> PERDEU; reset_n low mid-PREV_ON -> immediately IDLE, leds=0, counters 0.
- 16 wins -> ganhos stays 15; zera_metricas asserted in the same cycle as a win entry -> ganhos=0.
